// File: rtl/dct8_bfly_feed_pkg.sv
// Shared constants and state encoding for the 8-point DCT butterfly feeder.
// These stand in for the dct8_params.vh constants.
package dct8_bfly_feed_pkg;

  localparam int DCT8_IN_W      = 16;
  localparam int DCT8_FRAME_LEN = 8;
  localparam int DCT8_PAIR_CNT  = 4;

  typedef enum logic {
    ST_FILL = 1'b0,
    ST_EMIT = 1'b1
  } dct8_state_e;

endpackage

// File: rtl/dct8_bfly_addsub.sv
// Combinational butterfly add or subtract at DATA_W+1 bits, reduced to DATA_W.
// Define DCT8_BFLY_SAT_EN to saturate; otherwise the result wraps.
module dct8_bfly_addsub #(
  parameter int DATA_W = 16,
  parameter bit SUB    = 1'b0
) (
  input  logic signed [DATA_W-1:0] a,
  input  logic signed [DATA_W-1:0] b,
  output logic signed [DATA_W-1:0] res
);

  logic signed [DATA_W:0] full_s;

  // Full-precision sum or difference, then saturate or wrap into DATA_W.
  always_comb begin
    full_s = '0;
    res    = '0;
    if (SUB) begin
      full_s = {a[DATA_W-1], a} - {b[DATA_W-1], b};
    end else begin
      full_s = {a[DATA_W-1], a} + {b[DATA_W-1], b};
    end
`ifdef DCT8_BFLY_SAT_EN
    // The top two bits differ only when the result left the DATA_W range.
    if (full_s[DATA_W] != full_s[DATA_W-1]) begin
      if (full_s[DATA_W]) begin
        res = {1'b1, {(DATA_W-1){1'b0}}};
      end else begin
        res = {1'b0, {(DATA_W-1){1'b1}}};
      end
    end else begin
      res = full_s[DATA_W-1:0];
    end
`else
    res = full_s[DATA_W-1:0];
`endif
  end

endmodule

// File: rtl/dct8_bfly_feed.sv
// Collects an 8-sample frame, then presents the four butterfly pairs (s[k], d[k], k).
// Overflow handling is selected by the DCT8_BFLY_SAT_EN macro in dct8_bfly_addsub.
module dct8_bfly_feed
  import dct8_bfly_feed_pkg::*;
#(
  parameter int DATA_W = DCT8_IN_W,
  parameter int IDX_W  = 3
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic signed [DATA_W-1:0] in_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic signed [DATA_W-1:0] x_out,
  output logic signed [DATA_W-1:0] y_out,
  output logic [1:0]               angle_sel,
  output logic                     out_last
);

  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(DCT8_FRAME_LEN - 1);
  localparam logic [1:0]       LAST_PAIR = 2'(DCT8_PAIR_CNT - 1);

  dct8_state_e              state_r;
  logic [IDX_W-1:0]         wr_idx_r;
  logic [1:0]               k_r;
  logic                     in_ready_r;
  logic                     out_valid_r;
  logic signed [DATA_W-1:0] x_out_r;
  logic signed [DATA_W-1:0] y_out_r;
  logic [1:0]               angle_sel_r;
  logic                     out_last_r;
  logic signed [DATA_W-1:0] sample_mem_r [DCT8_FRAME_LEN];

  logic [1:0]               k_nxt_s;
  logic [IDX_W-1:0]         lo_idx_s;
  logic [IDX_W-1:0]         hi_idx_s;
  logic signed [DATA_W-1:0] op_a_s;
  logic signed [DATA_W-1:0] op_b_s;
  logic signed [DATA_W-1:0] sum_s;
  logic signed [DATA_W-1:0] diff_s;
  logic                     accept_s;
  logic                     emit_hs_s;

  assign accept_s  = (state_r == ST_FILL) && in_valid && in_ready_r;
  assign emit_hs_s = (state_r == ST_EMIT) && out_valid_r && out_ready;
  assign k_nxt_s   = k_r + 2'd1;

  // Operands for the pair registered at the next edge: pair 0 while the last
  // sample is arriving (x[7] taken straight from in_data), else pair k+1.
  always_comb begin
    lo_idx_s = '0;
    hi_idx_s = LAST_IDX;
    op_a_s   = '0;
    op_b_s   = '0;
    if (state_r == ST_FILL) begin
      lo_idx_s = '0;
      hi_idx_s = LAST_IDX;
      op_a_s   = sample_mem_r[lo_idx_s];
      op_b_s   = in_data;
    end else begin
      lo_idx_s = IDX_W'(k_nxt_s);
      hi_idx_s = LAST_IDX - lo_idx_s;
      op_a_s   = sample_mem_r[lo_idx_s];
      op_b_s   = sample_mem_r[hi_idx_s];
    end
  end

  dct8_bfly_addsub #(.DATA_W(DATA_W), .SUB(1'b0)) u_sum (
    .a   (op_a_s),
    .b   (op_b_s),
    .res (sum_s)
  );

  dct8_bfly_addsub #(.DATA_W(DATA_W), .SUB(1'b1)) u_diff (
    .a   (op_a_s),
    .b   (op_b_s),
    .res (diff_s)
  );

  // Sample buffer; contents are don't-care after reset, so it has none.
  always_ff @(posedge clk) begin
    if (accept_s) begin
      sample_mem_r[wr_idx_r] <= in_data;
    end
  end

  // Frame sequencer with registered handshake and pair outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= ST_FILL;
      wr_idx_r    <= '0;
      k_r         <= 2'd0;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
      x_out_r     <= '0;
      y_out_r     <= '0;
      angle_sel_r <= 2'd0;
      out_last_r  <= 1'b0;
    end else begin
      case (state_r)
        ST_FILL: begin
          if (accept_s) begin
            if (wr_idx_r == LAST_IDX) begin
              state_r     <= ST_EMIT;
              wr_idx_r    <= '0;
              k_r         <= 2'd0;
              in_ready_r  <= 1'b0;
              out_valid_r <= 1'b1;
              x_out_r     <= sum_s;
              y_out_r     <= diff_s;
              angle_sel_r <= 2'd0;
              out_last_r  <= 1'b0;
            end else begin
              wr_idx_r <= wr_idx_r + IDX_W'(1);
            end
          end else begin
            wr_idx_r <= wr_idx_r;
          end
        end
        ST_EMIT: begin
          if (emit_hs_s) begin
            if (k_r == LAST_PAIR) begin
              state_r     <= ST_FILL;
              k_r         <= 2'd0;
              in_ready_r  <= 1'b1;
              out_valid_r <= 1'b0;
            end else begin
              k_r         <= k_nxt_s;
              x_out_r     <= sum_s;
              y_out_r     <= diff_s;
              angle_sel_r <= k_nxt_s;
              out_last_r  <= (k_nxt_s == LAST_PAIR);
            end
          end else begin
            k_r <= k_r;
          end
        end
        default: begin
          state_r     <= ST_FILL;
          wr_idx_r    <= '0;
          k_r         <= 2'd0;
          in_ready_r  <= 1'b1;
          out_valid_r <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign x_out     = x_out_r;
  assign y_out     = y_out_r;
  assign angle_sel = angle_sel_r;
  assign out_last  = out_last_r;

endmodule
